fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small FIFO.
- Presents {inst, pc} to the decoder with a valid/ready handshake; a redirect input from branch/jump resolution flushes and re-steers fetch.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage; owns the PC, fetches words over req/gnt/rvalid, buffers them for the decoder
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   imem_req/addr/gnt          fetch request to instruction memory (one outstanding at most)
//   imem_rvalid/rdata          in-order read return
//   redirect/redirect_pc       flush the buffer and re-steer fetch
//   out_valid/inst/pc/ready    head of the instruction buffer to the decoder
//   out_misalign               only with FETCH_ALIGN_CHK_EN: entry comes from a misaligned redirect
// Build option FETCH_ALIGN_CHK_EN: misaligned redirects produce one flagged entry and halt fetch
// until the next redirect; without it the low two target bits are cleared.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
`ifdef FETCH_ALIGN_CHK_EN
   output logic        out_misalign,
`endif
   input  logic        out_ready
);
   localparam int AW = $clog2(QDEPTH);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_tgt, w_push_inst, w_push_pc;
   logic [31:0] r_q_inst [QDEPTH];
   logic [31:0] r_q_pc [QDEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0] r_cnt, w_cnt_nxt;
   logic r_drop, w_push, w_pop, w_space, w_outst, w_halt, w_tgt_mis, w_mis_push;

`ifdef FETCH_ALIGN_CHK_EN
   logic r_q_mis [QDEPTH];
   logic r_halt, r_mis_pend;
   assign w_tgt        = redirect_pc;
   assign w_tgt_mis    = redirect_pc[1:0] != 2'b00;
   assign w_halt       = r_halt;
   // the flagged entry is pushed the cycle after the redirect so out_valid stays low right after it
   assign w_mis_push   = r_mis_pend && !redirect;
   assign out_misalign = out_valid && r_q_mis[r_rp];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_halt     <= 1'b0;
         r_mis_pend <= 1'b0;
      end else begin
         r_halt     <= redirect ? w_tgt_mis : r_halt;
         r_mis_pend <= redirect && w_tgt_mis;
         if (w_push) r_q_mis[r_wp] <= w_mis_push;
      end
   end
`else
   assign w_tgt      = redirect_pc & ~32'd3;
   assign w_tgt_mis  = 1'b0;
   assign w_halt     = 1'b0;
   assign w_mis_push = 1'b0;
`endif

   assign imem_req    = r_state == S_REQ;
   assign imem_addr   = r_pc;
   assign out_valid   = r_cnt != '0;
   assign out_inst    = out_valid ? r_q_inst[r_rp] : '0;
   assign out_pc      = out_valid ? r_q_pc[r_rp] : '0;
   assign w_pop       = out_valid && out_ready;
   assign w_push      = !redirect && (w_mis_push || (r_state == S_WAIT && imem_rvalid && !r_drop));
   assign w_cnt_nxt   = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
   assign w_space     = w_cnt_nxt < (AW+1)'(QDEPTH);
   // a request stays in flight across a redirect if granted now or still awaiting data
   assign w_outst     = (r_state == S_REQ && imem_gnt) || (r_state == S_WAIT && !imem_rvalid);
   assign w_push_inst = w_mis_push ? '0 : imem_rdata;
   // pc already advanced past the in-flight word on grant
   assign w_push_pc   = w_mis_push ? r_pc : r_pc - 32'd4;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = (!w_halt && w_space) ? S_REQ : S_IDLE;
         S_REQ:   w_state_nxt = imem_gnt ? S_WAIT : S_REQ;
         S_WAIT:  w_state_nxt = !imem_rvalid ? S_WAIT : (w_space && !w_halt) ? S_REQ : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (redirect) w_state_nxt = w_outst ? S_WAIT : w_tgt_mis ? S_IDLE : S_REQ;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_drop  <= 1'b0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= redirect ? w_tgt : (imem_req && imem_gnt) ? r_pc + 32'd4 : r_pc;
         r_drop  <= redirect ? w_outst : (r_state == S_WAIT && imem_rvalid) ? 1'b0 : r_drop;
         if (redirect) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_push) begin
               r_q_inst[r_wp] <= w_push_inst;
               r_q_pc[r_wp]   <= w_push_pc;
            end
            r_wp  <= r_wp + AW'(w_push);
            r_rp  <= r_rp + AW'(w_pop);
            r_cnt <= w_cnt_nxt;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-configurable instruction memory model
module tb_fetch_unit;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        mis;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, imem_gnt = 1'b1, imem_rvalid = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0;
   logic        redirect = 1'b0, out_ready = 1'b1, out_valid;
   logic [31:0] redirect_pc = '0, out_inst, out_pc;
   logic        mis1, mis2;
   logic        req2, rvalid2 = 1'b0, ov2;
   logic [31:0] addr2, rdata2 = '0, oi2, op2;

   entry_t      sb[$];
   logic [31:0] seen[$];
   logic [31:0] seen2[$];
   logic [31:0] exp_pc, pend_addr, mis_pc;
   logic        pend, pend_stale, mis_pend, halt, found;
   int          pend_cnt, lat, n_fire, n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
`ifdef FETCH_ALIGN_CHK_EN
      .out_misalign(mis1),
`endif
      .out_ready(out_ready)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
      .imem_rvalid(rvalid2), .imem_rdata(rdata2),
      .redirect(1'b0), .redirect_pc(32'h0),
      .out_valid(ov2), .out_inst(oi2), .out_pc(op2),
`ifdef FETCH_ALIGN_CHK_EN
      .out_misalign(mis2),
`endif
      .out_ready(1'b1)
   );

`ifndef FETCH_ALIGN_CHK_EN
   assign mis1 = 1'b0;
   assign mis2 = 1'b0;
`endif

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic check_seen(input string tag, input int idx, input logic [31:0] exp);
      check({tag, "_present"}, 32'(seen.size() > idx), 32'd1);
      if (seen.size() > idx) check(tag, seen[idx], exp);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      redirect = 1'b0;
      imem_rvalid = 1'b0;
      rvalid2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_inst", out_inst, 32'd0);
      check("rst_pc", out_pc, 32'd0);
      check("rst_mis", 32'(mis1), 32'd0);
      check("rst_req2", 32'(req2), 32'd0);
      rst_n = 1'b1;
      sb.delete();
      seen.delete();
      seen2.delete();
      exp_pc = 32'h0;
      pend = 1'b0;
      pend_stale = 1'b0;
      mis_pend = 1'b0;
      halt = 1'b0;
      n_fire = 0;
   endtask

   task automatic step();
      logic fire, rv, pop, fire2, mis_now;
      logic [31:0] a2;
      entry_t e;
      fire = imem_req && imem_gnt;
      rv = imem_rvalid;
      pop = out_valid && out_ready;
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("depth", 32'(sb.size() <= 2), 32'd1);
      if (pop) begin
         seen.push_back(out_pc);
         if (sb.size() != 0) begin
            e = sb[0];
            check("out_pc", out_pc, e.pc);
            check("out_inst", out_inst, e.inst);
            check("out_mis", 32'(mis1), 32'(e.mis));
         end
      end
      if (fire) begin
         n_fire++;
         check("imem_addr", imem_addr, exp_pc);
         check("one_outstanding", 32'(pend), 32'd0);
         check("halted_req", 32'(halt), 32'd0);
      end
      fire2 = req2;
      a2 = addr2;
      if (ov2) begin
         seen2.push_back(op2);
         check("wrap_inst", oi2, mem_word(op2));
      end
      @(posedge clk);
      #1;
      if (pop && sb.size() != 0) void'(sb.pop_front());
      if (rv && pend) begin
         if (!pend_stale && !redirect) sb.push_back('{pc: pend_addr, inst: mem_word(pend_addr), mis: 1'b0});
         pend = 1'b0;
      end
      if (mis_pend && !redirect) sb.push_back('{pc: mis_pc, inst: 32'h0, mis: 1'b1});
      mis_pend = 1'b0;
      if (fire) begin
         pend = 1'b1;
         pend_addr = exp_pc;
         pend_cnt = lat;
         pend_stale = 1'b0;
         exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
         sb.delete();
         if (pend) pend_stale = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
         mis_now = redirect_pc[1:0] != 2'b00;
         exp_pc = redirect_pc;
`else
         mis_now = 1'b0;
         exp_pc = {redirect_pc[31:2], 2'b00};
`endif
         halt = mis_now;
         mis_pend = mis_now;
         mis_pc = redirect_pc;
      end
      if (pend && pend_cnt > 0) pend_cnt--;
      imem_rvalid = pend && pend_cnt == 0;
      imem_rdata = imem_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      rvalid2 = fire2;
      rdata2 = fire2 ? mem_word(a2) : 32'hDEAD_BEEF;
   endtask

   task automatic redirect_to(input logic [31:0] t);
      redirect = 1'b1;
      redirect_pc = t;
      step();
      redirect = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      // sequential fetch after reset, plus the wrapping RESET_PC instance
      lat = 1;
      out_ready = 1'b1;
      apply_reset();
      check("req_before_release_edge", 32'(imem_req), 32'd0);
      step();
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, 32'h0);
      repeat (10) step();
      check_seen("seq0", 0, 32'h0);
      check_seen("seq1", 1, 32'h4);
      check_seen("seq2", 2, 32'h8);
      check("wrap_n", 32'(seen2.size() >= 3), 32'd1);
      if (seen2.size() >= 3) begin
         check("wrap0", seen2[0], 32'hFFFF_FFF8);
         check("wrap1", seen2[1], 32'hFFFF_FFFC);
         check("wrap2", seen2[2], 32'h0000_0000);
      end

      // backpressure fills exactly two entries and stops requesting
      out_ready = 1'b0;
      apply_reset();
      repeat (10) step();
      check("bp_fires", n_fire, 2);
      check("bp_req_low", 32'(imem_req), 32'd0);
      check("bp_head", out_pc, 32'h0);
      out_ready = 1'b1;
      repeat (10) step();
      check_seen("bp0", 0, 32'h0);
      check_seen("bp1", 1, 32'h4);
      check_seen("bp2", 2, 32'h8);

      // redirect while the 0x8 word is in flight
      lat = 3;
      apply_reset();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         found = pend && pend_addr == 32'h8 && !imem_rvalid;
      end
      check("wait_0x8_granted", 32'(found), 32'd1);
      redirect_to(32'h100);
      check("redir_valid_low", 32'(out_valid), 32'd0);
      seen.delete();
      repeat (20) step();
      check_seen("redir_wait_first", 0, 32'h100);
      check_seen("redir_wait_second", 1, 32'h104);

      // redirect coincident with rvalid and a pop
      lat = 1;
      out_ready = 1'b0;
      apply_reset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         found = imem_rvalid && out_valid;
      end
      check("rvalid_and_valid_seen", 32'(found), 32'd1);
      out_ready = 1'b1;
      redirect_to(32'h200);
      check("coin_valid_low", 32'(out_valid), 32'd0);
      check("coin_req", 32'(imem_req), 32'd1);
      check("coin_addr", imem_addr, 32'h200);
      seen.delete();
      repeat (10) step();
      check_seen("coin_first", 0, 32'h200);

      // misaligned redirect
      apply_reset();
      repeat (5) step();
      redirect_to(32'h102);
      seen.delete();
      n_fire = 0;
      repeat (10) step();
`ifdef FETCH_ALIGN_CHK_EN
      check("mis_no_fetch", n_fire, 0);
      check("mis_entries", seen.size(), 1);
      check_seen("mis_pc", 0, 32'h102);
      redirect_to(32'h104);
      seen.delete();
      repeat (10) step();
      check_seen("mis_resume", 0, 32'h104);
`else
      check("align_fetches", 32'(n_fire > 0), 32'd1);
      check_seen("align_first", 0, 32'h100);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
